block_cost_engine: RTL
======================

Name: block_cost_engine

Overview:
Parametrised successor to the fixed 6x6 SSD block calculator in the stereo pipeline. It streams one row pair per handshake beat. For each row it extracts a BLOCK_W-pixel window from back/front row buffers on each side using a per-side shift, then computes per-pixel SSD or SAD and accumulates over BLOCK_H rows. The block cost is presented through a valid/ready output with an echoed tag, so the disparity search can pick the minimum. The block sits between the row-buffer manager and the disparity selector.

Parameters:
PIX_W, 8, bits per pixel (unsigned)
BLOCK_W, 6, pixels per block row (>=2)
BLOCK_H, 6, rows per block (>=2)
TAG_W, 9, width of the caller tag echoed with the result (e.g. disparity index)
COST_W, 2*PIX_W+$clog2(BLOCK_W*BLOCK_H), result width (derived, not overridden)

Ports:
clk_in  in  1  clock
rst_in  in  1  reset; asynchronous, active-high
flush_in  in  1  sync clear of the partial block and pipeline; the output register is untouched
row_valid  in  1  row beat valid
row_ready  out  1  row beat accepted when row_valid&&row_ready
mode_in  in  1  0=SSD, 1=SAD; sampled on the first row of a block
tag_in  in  TAG_W  sampled on the first row of a block
left_back_row  in  BLOCK_W*PIX_W  left back buffer row; pixel 0 at MSBs
left_front_row  in  BLOCK_W*PIX_W  left front buffer row
right_back_row  in  BLOCK_W*PIX_W  right back buffer row
right_front_row  in  BLOCK_W*PIX_W  right front buffer row
left_shift  in  $clog2(BLOCK_W)+1  left window start offset into {back,front}
right_shift  in  $clog2(BLOCK_W)+1  right window start offset
cost_valid  out  1  result valid
cost_ready  in  1  result consumed when cost_valid&&cost_ready
cost_out  out  COST_W  block cost
cost_tag  out  TAG_W  tag of this block
cost_mode  out  1  mode used for this block
shift_err  out  1  sticky; set when any accepted shift >= BLOCK_W

Behaviour:
- Reset (async): row counter 0, pipeline valids 0, accumulator 0, cost_valid 0, cost_out 0, cost_tag 0, cost_mode 0, shift_err 0. row_ready is 1 after reset deasserts.
- Window: form the 2*BLOCK_W-pixel vector {back,front}, pixel 0 = back MSB. The window is pixels s..s+BLOCK_W-1. s=0 gives back exactly. s>=BLOCK_W is clamped to BLOCK_W-1 and sets shift_err; shift_err clears only on reset.
- Pipeline, one row per cycle at full throughput:
  - S1 registers both windows, plus first/last flags.
  - S2 registers per-pixel signed difference (PIX_W+1 bits).
  - S3 registers the row sum: sum of d*d (SSD) or |d| (SAD), 2*PIX_W+$clog2(BLOCK_W) bits.
  - ACC: on the first row, acc=row sum; otherwise acc+=row sum. On the last row, the result is written to the output register.
- Latency: cost_valid rises 4 cycles after the clock edge that accepts row BLOCK_H-1.
- Row counter: counts accepted beats 0..BLOCK_H-1 and wraps to 0 after the last row. mode/tag are captured at count 0 and travel with the block.
- Backpressure: row_ready=0 from the cycle after the last row is accepted until the output register is empty, or is popped in the same cycle. A new block's rows may not enter while the previous result is unconsumed. This needs no extra buffering.
- Output: cost_out/cost_tag/cost_mode hold stable while cost_valid && !cost_ready. If a pop and a load occur in the same cycle, the load wins (cost_valid stays 1).
- SAD with all-max difference: max cost = (2^PIX_W-1)*BLOCK_W*BLOCK_H. SSD max = (2^PIX_W-1)^2*BLOCK_W*BLOCK_H. Both fit COST_W with no saturation logic.
- flush_in: clears the row counter, S1-S3 valids and the accumulator in the same cycle. A row beat presented alongside flush is not accepted (row_ready=0 that cycle). A pending output is kept.
- Reset asserted mid-block: abandon everything and return to the reset state immediately.
- row_valid low mid-block: bubbles propagate and the accumulator holds. No timeout.

Test Plan:
- Default params, SSD, all shifts 0; left rows all pixels 10, right rows all 7, 6 rows back-to-back -> cost_valid once, cost_out=6*6*9=324, latency 4 cycles after the 6th accept.
- Same data with mode_in=1 (SAD) and tag_in=37 -> cost_out=108, cost_tag=37, cost_mode=1.
- left back pixels 0..5 = 1..6, front = 7..12, left_shift=2, right rows = {3,4,5,6,7,8}, shift 0 -> cost 0; left_shift=3 -> SSD=36 (1 per pixel over 36 pixels).
- Hold cost_ready=0 for 20 cycles after a result while offering the next block -> row_ready=0 throughout and cost_out stable. Pulse cost_ready -> row_ready=1 next cycle, second block result correct.
- flush_in after 3 rows, then a full 6-row block of 255 vs 0 in SSD -> single result 65025*36=2340900, no contamination from the flushed rows.
- left_shift=7 with default params -> shift_err=1 and stays 1. Window equals shift 5. Async rst_in mid-block -> all outputs 0 without a clock edge.

Source files
------------

// File: rtl/block_cost_engine.sv
// Streaming block matcher: extracts shifted left/right windows per row, forms per-pixel
// SSD or SAD terms and accumulates them over BLOCK_H rows into a tagged valid/ready result.
module block_cost_engine #(
   parameter int PIX_W   = 8,
   parameter int BLOCK_W = 6,
   parameter int BLOCK_H = 6,
   parameter int TAG_W   = 9,
   localparam int COST_W = 2*PIX_W + $clog2(BLOCK_W*BLOCK_H),
   localparam int SH_W   = $clog2(BLOCK_W) + 1
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     flush_in,
   input  logic                     row_valid,
   output logic                     row_ready,
   input  logic                     mode_in,
   input  logic [TAG_W-1:0]         tag_in,
   input  logic [BLOCK_W*PIX_W-1:0] left_back_row,
   input  logic [BLOCK_W*PIX_W-1:0] left_front_row,
   input  logic [BLOCK_W*PIX_W-1:0] right_back_row,
   input  logic [BLOCK_W*PIX_W-1:0] right_front_row,
   input  logic [SH_W-1:0]          left_shift,
   input  logic [SH_W-1:0]          right_shift,
   output logic                     cost_valid,
   input  logic                     cost_ready,
   output logic [COST_W-1:0]        cost_out,
   output logic [TAG_W-1:0]         cost_tag,
   output logic                     cost_mode,
   output logic                     shift_err
);

   localparam int ROW_BITS = BLOCK_W*PIX_W;
   localparam int CAT_BITS = 2*ROW_BITS;
   localparam int IDX_W    = $clog2(CAT_BITS);
   localparam int CNT_W    = $clog2(BLOCK_H);
   localparam int ROW_W    = 2*PIX_W + $clog2(BLOCK_W);

   logic                accept, first_row, last_row, ls_bad, rs_bad;
   logic [SH_W-1:0]     ls_cl, rs_cl;
   logic [IDX_W-1:0]    l_base, r_base;
   logic [CAT_BITS-1:0] l_cat, r_cat;
   logic [ROW_BITS-1:0] l_win, r_win;

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                blk_mode_q, blk_mode_d;
   logic [TAG_W-1:0]    blk_tag_q, blk_tag_d;
   logic                s1_v_q, s1_v_d, s2_v_q, s2_v_d, s3_v_q, s3_v_d, done_q, done_d;
   logic [COST_W-1:0]   acc_q, acc_d;
   logic                inflight_q, inflight_d;
   logic                shift_err_q, shift_err_d;
   logic                cost_valid_q, cost_valid_d, cost_mode_q, cost_mode_d;
   logic [COST_W-1:0]   cost_out_q, cost_out_d;
   logic [TAG_W-1:0]    cost_tag_q, cost_tag_d;

   logic [ROW_BITS-1:0] s1_l_q, s1_r_q;
   logic                s1_first_q, s1_last_q, s1_mode_q;
   logic [TAG_W-1:0]    s1_tag_q;
   logic signed [PIX_W:0] diff_d    [BLOCK_W];
   logic signed [PIX_W:0] s2_diff_q [BLOCK_W];
   logic                s2_first_q, s2_last_q, s2_mode_q;
   logic [TAG_W-1:0]    s2_tag_q;
   logic [PIX_W-1:0]    mag [BLOCK_W];
   logic [2*PIX_W-1:0]  sq  [BLOCK_W];
   logic [ROW_W-1:0]    row_sum_d, s3_sum_q;
   logic                s3_first_q, s3_last_q, s3_mode_q;
   logic [TAG_W-1:0]    s3_tag_q;
   logic                done_mode_q;
   logic [TAG_W-1:0]    done_tag_q;

   // A new block may only start once the previous result has left (or is leaving) the output.
   assign row_ready = !flush_in && !inflight_q && (!cost_valid_q || cost_ready);
   assign accept    = row_valid && row_ready;
   assign first_row = (cnt_q == '0);
   assign last_row  = (cnt_q == CNT_W'(BLOCK_H-1));

   assign cost_valid = cost_valid_q;
   assign cost_out   = cost_out_q;
   assign cost_tag   = cost_tag_q;
   assign cost_mode  = cost_mode_q;
   assign shift_err  = shift_err_q;

   // Window start s selects pixels s..s+BLOCK_W-1 of {back,front}; out-of-range s clamps.
   always_comb begin
      l_cat  = {left_back_row, left_front_row};
      r_cat  = {right_back_row, right_front_row};
      ls_bad = (left_shift >= SH_W'(BLOCK_W));
      rs_bad = (right_shift >= SH_W'(BLOCK_W));
      ls_cl  = ls_bad ? SH_W'(BLOCK_W-1) : left_shift;
      rs_cl  = rs_bad ? SH_W'(BLOCK_W-1) : right_shift;
      l_base = IDX_W'(CAT_BITS - 1 - int'(ls_cl) * PIX_W);
      r_base = IDX_W'(CAT_BITS - 1 - int'(rs_cl) * PIX_W);
      l_win  = l_cat[l_base -: ROW_BITS];
      r_win  = r_cat[r_base -: ROW_BITS];
   end

   generate
      for (genvar gi = 0; gi < BLOCK_W; gi++) begin : g_pix
         assign diff_d[gi] = $signed({1'b0, s1_l_q[(BLOCK_W-1-gi)*PIX_W +: PIX_W]})
                           - $signed({1'b0, s1_r_q[(BLOCK_W-1-gi)*PIX_W +: PIX_W]});
         assign mag[gi] = s2_diff_q[gi][PIX_W] ? PIX_W'(-s2_diff_q[gi]) : s2_diff_q[gi][PIX_W-1:0];
         assign sq[gi]  = {{PIX_W{1'b0}}, mag[gi]} * {{PIX_W{1'b0}}, mag[gi]};
      end
   endgenerate

   always_comb begin
      row_sum_d = '0;
      for (int k = 0; k < BLOCK_W; k++) begin
         row_sum_d = row_sum_d + (s2_mode_q ? ROW_W'(mag[k]) : ROW_W'(sq[k]));
      end
   end

   always_comb begin
      cnt_d        = cnt_q;
      blk_mode_d   = blk_mode_q;
      blk_tag_d    = blk_tag_q;
      s1_v_d       = accept;
      s2_v_d       = s1_v_q && !flush_in;
      s3_v_d       = s2_v_q && !flush_in;
      done_d       = s3_v_q && s3_last_q && !flush_in;
      acc_d        = acc_q;
      inflight_d   = inflight_q;
      shift_err_d  = shift_err_q || (accept && (ls_bad || rs_bad));
      cost_valid_d = cost_valid_q;
      cost_out_d   = cost_out_q;
      cost_tag_d   = cost_tag_q;
      cost_mode_d  = cost_mode_q;

      if (flush_in) begin
         cnt_d = '0;
      end else if (accept) begin
         cnt_d = last_row ? '0 : cnt_q + CNT_W'(1);
         if (first_row) begin
            blk_mode_d = mode_in;
            blk_tag_d  = tag_in;
         end
      end

      if (flush_in) begin
         acc_d = '0;
      end else if (s3_v_q) begin
         acc_d = s3_first_q ? COST_W'(s3_sum_q) : acc_q + COST_W'(s3_sum_q);
      end

      if (flush_in) begin
         inflight_d = 1'b0;
      end else if (accept && last_row) begin
         inflight_d = 1'b1;
      end else if (done_q) begin
         inflight_d = 1'b0;
      end

      // Load beats pop: a result landing in the same cycle as a pop keeps cost_valid high.
      if (done_q && !flush_in) begin
         cost_valid_d = 1'b1;
         cost_out_d   = acc_q;
         cost_tag_d   = done_tag_q;
         cost_mode_d  = done_mode_q;
      end else if (cost_ready) begin
         cost_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         cnt_q        <= '0;
         blk_mode_q   <= 1'b0;
         blk_tag_q    <= '0;
         s1_v_q       <= 1'b0;
         s2_v_q       <= 1'b0;
         s3_v_q       <= 1'b0;
         done_q       <= 1'b0;
         acc_q        <= '0;
         inflight_q   <= 1'b0;
         shift_err_q  <= 1'b0;
         cost_valid_q <= 1'b0;
         cost_out_q   <= '0;
         cost_tag_q   <= '0;
         cost_mode_q  <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         blk_mode_q   <= blk_mode_d;
         blk_tag_q    <= blk_tag_d;
         s1_v_q       <= s1_v_d;
         s2_v_q       <= s2_v_d;
         s3_v_q       <= s3_v_d;
         done_q       <= done_d;
         acc_q        <= acc_d;
         inflight_q   <= inflight_d;
         shift_err_q  <= shift_err_d;
         cost_valid_q <= cost_valid_d;
         cost_out_q   <= cost_out_d;
         cost_tag_q   <= cost_tag_d;
         cost_mode_q  <= cost_mode_d;
      end
   end

   // Datapath registers are qualified by the valid bits above and need no reset.
   always_ff @(posedge clk_in) begin
      s1_l_q      <= l_win;
      s1_r_q      <= r_win;
      s1_first_q  <= first_row;
      s1_last_q   <= last_row;
      s1_mode_q   <= first_row ? mode_in : blk_mode_q;
      s1_tag_q    <= first_row ? tag_in : blk_tag_q;
      s2_diff_q   <= diff_d;
      s2_first_q  <= s1_first_q;
      s2_last_q   <= s1_last_q;
      s2_mode_q   <= s1_mode_q;
      s2_tag_q    <= s1_tag_q;
      s3_sum_q    <= row_sum_d;
      s3_first_q  <= s2_first_q;
      s3_last_q   <= s2_last_q;
      s3_mode_q   <= s2_mode_q;
      s3_tag_q    <= s2_tag_q;
      done_mode_q <= s3_mode_q;
      done_tag_q  <= s3_tag_q;
   end

endmodule
